// File: rtl/mem_bus_if.sv
// Pipeline-side request interface of the MEM-stage data-memory bus controller.
// Handshake: the requester raises req_read_i/req_write_i with addr_i/wdata_i and keeps
// them stable while busy_o is high. done_o pulses for one cycle when the access ends
// (busy_o is low then), and the requester must drop the request in that same cycle.
interface mem_bus_if;
  logic        req_read_i;
  logic        req_write_i;
  logic [15:0] addr_i;
  logic [15:0] wdata_i;
  logic [15:0] rdata_o;
  logic        busy_o;
  logic        done_o;

  modport master (
    output req_read_i, req_write_i, addr_i, wdata_i,
    input  rdata_o, busy_o, done_o
  );

  modport slave (
    input  req_read_i, req_write_i, addr_i, wdata_i,
    output rdata_o, busy_o, done_o
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// MEM-stage responder driving the shared Ram1 SRAM / UART bus with the right strobe sequence.
// Define MEMBUS_UART_EN to decode the UART data/status addresses; otherwise everything is SRAM.
module mem_bus_ctrl #(
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01,
  parameter logic [1:0]  RAM1_ADDR_HI   = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  mem_bus_if.slave    bus,
  output logic [17:0] Ram1Addr,
  inout  wire  [15:0] Ram1Data,
  output logic        Ram1OE,
  output logic        Ram1WE,
  output logic        Ram1EN,
  output logic        rdn,
  output logic        wrn,
  input  logic        data_ready,
  input  logic        tbre,
  input  logic        tsre,
  output logic [3:0]  state_dbg
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    SR_RD  = 4'd1,
    SR_WR1 = 4'd2,
    SR_WR2 = 4'd3,
`ifdef MEMBUS_UART_EN
    U_RD1  = 4'd4,
    U_RD2  = 4'd5,
    U_WR1  = 4'd6,
    U_WR2  = 4'd7,
`endif
    DONE   = 4'd8
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic        req_any;
  logic        is_write;
  logic        bus_drive;
  logic        start;

  assign req_any  = bus.req_read_i | bus.req_write_i;
  assign is_write = bus.req_write_i;
  assign start    = (state == IDLE) && req_any;

`ifdef MEMBUS_UART_EN
  logic sel_data;
  logic sel_stat;
  assign sel_data = (bus.addr_i == UART_DATA_ADDR);
  assign sel_stat = (bus.addr_i == UART_STAT_ADDR);
`else
  logic unused_uart;
  assign unused_uart = ^{data_ready, tbre, tsre, UART_DATA_ADDR, UART_STAT_ADDR};
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_any) begin
`ifdef MEMBUS_UART_EN
          if (sel_stat) begin
            state_nxt = DONE;
          end else if (sel_data) begin
            state_nxt = is_write ? U_WR1 : U_RD1;
          end else begin
            state_nxt = is_write ? SR_WR1 : SR_RD;
          end
`else
          state_nxt = is_write ? SR_WR1 : SR_RD;
`endif
        end
      end
      SR_RD:  state_nxt = DONE;
      SR_WR1: state_nxt = SR_WR2;
      SR_WR2: state_nxt = DONE;
`ifdef MEMBUS_UART_EN
      U_RD1:  state_nxt = U_RD2;
      U_RD2:  state_nxt = DONE;
      U_WR1:  state_nxt = U_WR2;
      U_WR2:  state_nxt = DONE;
`endif
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes decode straight from state; Ram1EN stays high outside SRAM states so the
  // UART and SRAM can never both drive Ram1Data.
  always_comb begin
    Ram1EN    = 1'b1;
    Ram1OE    = 1'b1;
    Ram1WE    = 1'b1;
    rdn       = 1'b1;
    wrn       = 1'b1;
    bus_drive = 1'b0;
    case (state)
      SR_RD: begin
        Ram1EN = 1'b0;
        Ram1OE = 1'b0;
      end
      SR_WR1: begin
        Ram1EN    = 1'b0;
        Ram1WE    = 1'b0;
        bus_drive = 1'b1;
      end
      SR_WR2: begin
        Ram1EN    = 1'b0;
        bus_drive = 1'b1;
      end
`ifdef MEMBUS_UART_EN
      U_RD1, U_RD2: begin
        rdn = 1'b0;
      end
      U_WR1: begin
        wrn       = 1'b0;
        bus_drive = 1'b1;
      end
      U_WR2: begin
        bus_drive = 1'b1;
      end
`endif
      default: begin
        bus_drive = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (start) begin
        addr_q  <= bus.addr_i;
        wdata_q <= bus.wdata_i;
      end
`ifdef MEMBUS_UART_EN
      // Status is sampled on the request edge so it is already valid in DONE.
      if (start && sel_stat && !is_write) begin
        rdata_q <= {14'b0, data_ready, tbre & tsre};
      end
      if (state == U_RD2) begin
        rdata_q <= {8'h00, Ram1Data[7:0]};
      end
`endif
      if (state == SR_RD) begin
        rdata_q <= Ram1Data;
      end
    end
  end

  assign Ram1Data    = bus_drive ? wdata_q : 16'hzzzz;
  assign Ram1Addr    = {RAM1_ADDR_HI, addr_q};
  assign bus.rdata_o = rdata_q;
  assign bus.done_o  = (state == DONE);
  // The stall must rise in the request cycle itself, hence the combinational IDLE term.
  assign bus.busy_o  = rst & (start | ((state != IDLE) && (state != DONE)));
  assign state_dbg   = state;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: SRAM/UART bus models, expected-read scoreboard,
// strobe counting per transaction; UART cases follow the MEMBUS_UART_EN build.
module tb_mem_bus_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_bus_if bus ();

  wire  [15:0] ram1_data;
  logic [17:0] ram1_addr;
  logic        ram1_oe, ram1_we, ram1_en, rdn, wrn;
  logic        data_ready, tbre, tsre;
  logic [3:0]  state_dbg;

  mem_bus_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus),
    .Ram1Addr(ram1_addr), .Ram1Data(ram1_data),
    .Ram1OE(ram1_oe), .Ram1WE(ram1_we), .Ram1EN(ram1_en),
    .rdn(rdn), .wrn(wrn),
    .data_ready(data_ready), .tbre(tbre), .tsre(tsre),
    .state_dbg(state_dbg)
  );

  // Bus models: SRAM answers when enabled with OE low, UART answers while rdn is low.
  logic [15:0] sram [0:1023];
  logic [15:0] uart_rx;
  assign ram1_data = (!ram1_en && !ram1_oe) ? sram[ram1_addr[9:0]] :
                     (!rdn ? uart_rx : 16'hzzzz);
  always @(posedge clk) begin
    if (!ram1_en && !ram1_we) sram[ram1_addr[9:0]] <= ram1_data;
  end

  logic [15:0] ref_mem [0:1024-1];
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  int r_lat, r_we, r_oe, r_rdn, r_wrn, r_drv, r_busy, r_en;
  logic [17:0] r_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One request; counts strobe cycles between the request and done_o.
  task automatic run_txn(input string tag, input bit rd, input bit wr,
                         input logic [15:0] a, input logic [15:0] d, input int exp_lat);
    bit done_seen;
    @(negedge clk);
    bus.req_read_i = rd; bus.req_write_i = wr; bus.addr_i = a; bus.wdata_i = d;
    #1;
    r_lat = 0; r_we = 0; r_oe = 0; r_rdn = 0; r_wrn = 0; r_drv = 0; r_en = 0;
    r_busy = int'(bus.busy_o);
    r_addr = '0;
    done_seen = 1'b0;
    check({tag, " done idle"}, bus.done_o, 1'b0);
    while (!done_seen && r_lat < 10) begin
      @(posedge clk);
      @(negedge clk);
      r_lat++;
      if (ram1_oe && rdn && (ram1_data === d)) r_drv++;
      if (bus.done_o) begin
        done_seen = 1'b1;
      end else begin
        r_busy += int'(bus.busy_o);
        r_we   += int'(!ram1_we);
        r_oe   += int'(!ram1_oe);
        r_rdn  += int'(!rdn);
        r_wrn  += int'(!wrn);
        if (!ram1_en) begin
          r_en++;
          r_addr = ram1_addr;
        end
      end
    end
    bus.req_read_i = 1'b0;
    bus.req_write_i = 1'b0;
    check({tag, " latency"}, r_lat, exp_lat);
    check({tag, " busy at done"}, bus.busy_o, 1'b0);
    if (rd && !wr && done_seen) begin
      if (exp_q.size() == 0) check({tag, " scoreboard empty"}, 1, 0);
      else check({tag, " rdata"}, bus.rdata_o, exp_q.pop_front());
    end
  endtask

  task automatic sram_write(input logic [15:0] a, input logic [15:0] d);
    run_txn("sram wr", 1'b0, 1'b1, a, d, 3);
    ref_mem[a[9:0]] = d;
    check("sram wr we_lo", r_we, 1);
    check("sram wr oe_lo", r_oe, 0);
    check("sram wr addr", r_addr, {2'b00, a});
    check("sram wr busy", r_busy, 3);
    check("sram wr drive", r_drv, 2);
    check("sram wr uart strobes", r_rdn + r_wrn, 0);
  endtask

  task automatic sram_read(input logic [15:0] a);
    exp_q.push_back(ref_mem[a[9:0]]);
    run_txn("sram rd", 1'b1, 1'b0, a, 16'hC3C3, 2);
    check("sram rd oe_lo", r_oe, 1);
    check("sram rd we_lo", r_we, 0);
    check("sram rd addr", r_addr, {2'b00, a});
    check("sram rd busy", r_busy, 2);
    check("sram rd no drive", r_drv, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] addrs [0:5];
    logic [15:0] a, d;
    int done_cnt;
    bus.req_read_i = 1'b0; bus.req_write_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;
    data_ready = 1'b0; tbre = 1'b0; tsre = 1'b0; uart_rx = 16'h0000;
    for (int i = 0; i < 1024; i++) begin
      sram[i] = 16'h0000;
      ref_mem[i] = 16'h0000;
    end

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst strobes", {ram1_en, ram1_oe, ram1_we, rdn, wrn}, 5'b11111);
    check("rst addr", ram1_addr, 18'h0);
    check("rst rdata", bus.rdata_o, 16'h0);
    check("rst done", bus.done_o, 1'b0);
    bus.req_write_i = 1'b1;
    #1;
    check("rst busy forced", bus.busy_o, 1'b0);
    bus.req_write_i = 1'b0;
    rst = 1'b1;

    // SRAM write then read
    sram_write(16'h0040, 16'h1234);
    sram_read(16'h0040);

    // Simultaneous read+write: write wins
    run_txn("rd+wr", 1'b1, 1'b1, 16'h0010, 16'hA5A5, 3);
    ref_mem[10'h010] = 16'hA5A5;
    check("rd+wr we_lo", r_we, 1);
    check("rd+wr oe_lo", r_oe, 0);
    check("rd+wr rdata untouched", bus.rdata_o, 16'h1234);
    sram_read(16'h0010);
    sram_write(16'h0020, 16'h1111);
    check("rdata hold after write", bus.rdata_o, 16'hA5A5);

    // Random write/read-back
    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom_range(16'h0100, 16'h01FF));
      d = 16'($urandom_range(1, 16'hFFFF));
      addrs[i] = a;
      sram_write(a, d);
    end
    for (int i = 5; i >= 0; i--) sram_read(addrs[i]);

    // Reset during SR_WR1
    @(negedge clk);
    bus.req_write_i = 1'b1; bus.addr_i = 16'h0080; bus.wdata_i = 16'hBEEF;
    @(posedge clk);
    @(negedge clk);
    check("abort in wr1 we", ram1_we, 1'b0);
    rst = 1'b0;
    #1;
    check("abort busy forced", bus.busy_o, 1'b0);
    @(posedge clk);
    #1;
    check("abort strobes", {ram1_en, ram1_oe, ram1_we, rdn, wrn}, 5'b11111);
    check("abort bus released", ram1_data === 16'hBEEF, 1'b0);
    check("abort addr", ram1_addr, 18'h0);
    bus.req_write_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    done_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      done_cnt += int'(bus.done_o);
    end
    check("abort no done", done_cnt, 0);

`ifdef MEMBUS_UART_EN
    run_txn("uart wr", 1'b0, 1'b1, 16'hBF00, 16'h0041, 3);
    check("uart wr wrn_lo", r_wrn, 1);
    check("uart wr drive", r_drv, 2);
    check("uart wr en_lo", r_en, 0);
    check("uart wr busy", r_busy, 3);
    check("uart wr we_lo", r_we, 0);

    uart_rx = 16'hA55A; data_ready = 1'b1;
    exp_q.push_back(16'h005A);
    run_txn("uart rd", 1'b1, 1'b0, 16'hBF00, 16'hC3C3, 3);
    check("uart rd rdn_lo", r_rdn, 2);
    check("uart rd en_lo", r_en, 0);
    check("uart rd oe_lo", r_oe, 0);

    data_ready = 1'b1; tbre = 1'b1; tsre = 1'b0;
    exp_q.push_back(16'h0002);
    run_txn("stat rd", 1'b1, 1'b0, 16'hBF01, 16'hC3C3, 1);
    check("stat rd strobes", r_rdn + r_wrn + r_en, 0);

    data_ready = 1'b0; tbre = 1'b1; tsre = 1'b1;
    exp_q.push_back(16'h0001);
    run_txn("stat rd2", 1'b1, 1'b0, 16'hBF01, 16'hC3C3, 1);

    run_txn("stat wr", 1'b0, 1'b1, 16'hBF01, 16'hFFFF, 1);
    check("stat wr no strobes", r_rdn + r_wrn + r_en + r_drv, 0);
    check("stat wr rdata hold", bus.rdata_o, 16'h0001);
`else
    data_ready = 1'b1; tbre = 1'b1; tsre = 1'b1; uart_rx = 16'h7777;
    sram_write(16'hBF00, 16'h0041);
    sram_read(16'hBF00);
    sram_write(16'hBF01, 16'h5A5A);
    sram_read(16'hBF01);
`endif

    check("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

- Responder for the data-memory requests issued by the MEM stage.
- Turns each read or write request into the correct strobe sequence on the shared Ram1 SRAM / UART bus.
- Stalls the pipeline through `busy_o` until the access completes, then pulses `done_o`.
- Sits between the `mem` stage and the board pins `Ram1*`, `rdn` and `wrn`.

## Interface
Parameters:
- `UART_DATA_ADDR`, default 16'hBF00: address of the UART data register.
- `UART_STAT_ADDR`, default 16'hBF01: address of the UART status register.
- `RAM1_ADDR_HI`, default 2'b00: upper two bits of `Ram1Addr`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- `clk` input 1: system clock. All state changes on the rising edge.
- `rst` input 1: synchronous reset, active low.
- `req_read_i` input 1: read request. Held stable by the requester while `busy_o` is high.
- `req_write_i` input 1: write request. Same holding rule.
- `addr_i` input 16: word address.
- `wdata_i` input 16: write data.
- `rdata_o` output 16: read result, registered.
- `busy_o` output 1: stall to the pipeline (PC, IF/ID, ID/EX, EX/MEM hold).
- `done_o` output 1: one-cycle completion pulse.
- `Ram1Addr` output 18: SRAM address, equal to {`RAM1_ADDR_HI`, latched addr}.
- `Ram1Data` inout 16: shared SRAM/UART data bus.
- `Ram1OE`, `Ram1WE`, `Ram1EN` output 1 each: SRAM strobes, active low.
- `rdn`, `wrn` output 1 each: UART read and write strobes, active low.
- `data_ready` input 1: UART receive byte available.
- `tbre` input 1: UART transmit buffer empty.
- `tsre` input 1: UART transmit shift register empty.

## Operation
- States: IDLE, SR_RD, SR_WR1, SR_WR2, U_RD1, U_RD2, U_WR1, U_WR2, DONE.
- In IDLE, when a request is present, latch `addr_i` and `wdata_i` and decode the target.
- If `req_read_i` and `req_write_i` are both high, the write wins.
- SRAM read: IDLE -> SR_RD -> DONE.
  - In SR_RD: `Ram1EN`=0, `Ram1OE`=0, bus released (Z).
  - `rdata_o` <= `Ram1Data` at the end of SR_RD.
- SRAM write: IDLE -> SR_WR1 -> SR_WR2 -> DONE.
  - In SR_WR1: `Ram1EN`=0, `Ram1WE`=0, bus driven with the latched data.
  - In SR_WR2: `Ram1WE`=1, data still driven (hold time).
- UART data read: IDLE -> U_RD1 -> U_RD2 -> DONE.
  - `rdn`=0 in both states; `Ram1EN`=1; bus released (Z).
  - `rdata_o` <= {8'h00, `Ram1Data[7:0]`} at the end of U_RD2.
- UART data write: IDLE -> U_WR1 -> U_WR2 -> DONE.
  - In U_WR1: bus driven with the latched data, `wrn`=0.
  - In U_WR2: `wrn`=1, data still driven.
- Status read: IDLE -> DONE. `rdata_o` <= {14'b0, `data_ready`, `tbre`&`tsre`}. No bus strobes.
- Status write: IDLE -> DONE. No side effect.
- The hardware does not gate UART data accesses on `data_ready`, `tbre` or `tsre`; software polls the status register first.
- `Ram1EN` is held high in every non-SRAM state, so the UART and the SRAM never drive the bus together.
- `Ram1Data` is driven only in SR_WR1, SR_WR2, U_WR1 and U_WR2; it is Z otherwise.

## Timing
- `busy_o` = (IDLE & (`req_read_i` | `req_write_i`)) | (state ∉ {IDLE, DONE}). Combinational, so the stall takes effect in the request cycle.
- `done_o` = (state == DONE). `busy_o` is 0 in DONE, so the pipeline advances on that edge.
- Latency, request cycle to `done_o`: status 1 cycle, SRAM read 2, UART read 3, SRAM write 3, UART write 3.
- `rdata_o` holds its value until the next read completes. Writes do not change it.
- DONE always returns to IDLE. A request still high in the cycle after DONE starts a new transaction; the requester must drop it.
- Reset values (`rst`=0 at a clock edge):
  - state IDLE;
  - `Ram1EN`=`Ram1OE`=`Ram1WE`=`rdn`=`wrn`=1;
  - `Ram1Addr`=0, `Ram1Data`=Z;
  - `rdata_o`=0, `done_o`=0;
  - `busy_o` forced to 0 while `rst`=0.
- Reset mid-transaction aborts the access; all strobes return high at that edge.

## Configuration
- `MEMBUS_UART_EN` defined: the UART addresses decode as described above.
- Not defined:
  - every address maps to SRAM, including `UART_DATA_ADDR` and `UART_STAT_ADDR`;
  - `rdn`=`wrn`=1 permanently;
  - U_* states are not built;
  - `data_ready`, `tbre` and `tsre` are ignored.

## Test plan
- SRAM write then read:
  - write addr 16'h0040 with data 16'h1234 -> `Ram1WE` low for exactly 1 cycle, `Ram1Addr`=18'h00040, `done_o` 3 cycles after the request;
  - read the same address -> `rdata_o`=16'h1234, `done_o` 2 cycles after the request.
- UART write 16'h0041 to 16'hBF00 -> `wrn` low for 1 cycle, bus carries 16'h0041 for 2 cycles, `Ram1EN`=1 throughout, `busy_o` high for 3 cycles.
- UART read with the model driving 16'h005A and `data_ready`=1 -> `rdn` low for 2 cycles, `rdata_o`=16'h005A.
- Status read with `data_ready`=1, `tbre`=1, `tsre`=0 -> `rdata_o`=16'h0002 and `done_o` in the next cycle.
- `rst` asserted during SR_WR1 -> all strobes high at that edge, `Ram1Data`=Z, no `done_o`.
- `req_read_i` and `req_write_i` high together at 16'h0010 -> write sequence only. Build without `MEMBUS_UART_EN` and write to 16'hBF00 -> SRAM write at 18'h0BF00, `wrn` stays high.
